// File: rtl/rom_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter_pkg
// Shared definitions for the two-master ROM port arbiter:
//   - arb_state_t     : arbiter FSM state encoding
//   - MST_FETCH/DATA  : master indices used for ownership and priority
//   - TIMEOUT_DEFAULT : default WAIT-cycle budget before an error response
//   - CNT_W           : width of the WAIT-cycle counter (covers TIMEOUT 2..255)
// -----------------------------------------------------------------------------
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic MST_FETCH = 1'b0;
    localparam logic MST_DATA  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/rom_port_arbiter_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin picker.
//   req   : qualified requests, bit 0 = fetch master, bit 1 = data master
//   prio  : master that wins when both request (the one not granted last)
//   grant : one-hot grant, all zero when nobody requests
// -----------------------------------------------------------------------------
module rr_grant2
    import rom_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    // Single requester always wins; a tie goes to the priority master.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (prio == MST_DATA) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
// Shares one ROM read port between a fetch master (0) and a data master (1).
// One transaction is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   fRequest_i/fAddr_i                 fetch request (level) and byte address
//   fData_o/fDataOk_o/fErr_o           fetch response data, pulse, timeout flag
//   dRequest_i/dAddr_i                 data request (level) and byte address
//   dData_o/dDataOk_o/dErr_o           data response data, pulse, timeout flag
//   request_o/addr_o                   memory request pulse and held address
//   data_i/dataOk_i                    memory read data and valid
// -----------------------------------------------------------------------------
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fRequest_i,
    input  logic [ADDR_W-1:0] fAddr_i,
    output logic [DATA_W-1:0] fData_o,
    output logic              fDataOk_o,
    output logic              fErr_o,
    input  logic              dRequest_i,
    input  logic [ADDR_W-1:0] dAddr_i,
    output logic [DATA_W-1:0] dData_o,
    output logic              dDataOk_o,
    output logic              dErr_o,
    output logic              request_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              dataOk_i
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic              prio_r;
    logic              owner_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              request_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] f_data_r;
    logic              f_ok_r;
    logic              f_err_r;
    logic [DATA_W-1:0] d_data_r;
    logic              d_ok_r;
    logic              d_err_r;

    logic [1:0]        req_q_s;
    logic [1:0]        grant_s;
    logic              grant_fire_s;
    logic              resp_fire_s;
    logic              timeout_s;
    logic [DATA_W-1:0] resp_data_s;

    // A held request is masked while its own response pulse is out, so the
    // same request is never granted twice.
    always_comb begin
        req_q_s = {dRequest_i & ~d_ok_r, fRequest_i & ~f_ok_r};
    end

    rr_grant2 u_rr_grant2 (
        .req   (req_q_s),
        .prio  (prio_r),
        .grant (grant_s)
    );

    // Next-state logic; a dataOk_i on the last WAIT cycle beats the timeout.
    always_comb begin
        next_state_s = state_r;
        grant_fire_s = 1'b0;
        resp_fire_s  = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    next_state_s = ST_ISSUE;
                    grant_fire_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (dataOk_i) begin
                    next_state_s = ST_RESP;
                    resp_fire_s  = 1'b1;
                end else if (cnt_r == LAST_CNT) begin
                    next_state_s = ST_RESP;
                    resp_fire_s  = 1'b1;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Response payload: memory data on success, zero on timeout.
    always_comb begin
        if (timeout_s) begin
            resp_data_s = {DATA_W{1'b0}};
        end else begin
            resp_data_s = data_i;
        end
    end

    // FSM state, grant bookkeeping, memory request and WAIT counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            prio_r    <= MST_FETCH;
            owner_r   <= MST_FETCH;
            cnt_r     <= {CNT_W{1'b0}};
            request_r <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= next_state_s;
            request_r <= grant_fire_s;
            if (grant_fire_s) begin
                owner_r <= grant_s[1];
                prio_r  <= ~grant_s[1];
                addr_r  <= grant_s[1] ? dAddr_i : fAddr_i;
            end
            if (state_r == ST_ISSUE) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_WAIT) && !resp_fire_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Per-master response registers; data holds between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_data_r <= {DATA_W{1'b0}};
            f_ok_r   <= 1'b0;
            f_err_r  <= 1'b0;
            d_data_r <= {DATA_W{1'b0}};
            d_ok_r   <= 1'b0;
            d_err_r  <= 1'b0;
        end else begin
            f_ok_r  <= 1'b0;
            f_err_r <= 1'b0;
            d_ok_r  <= 1'b0;
            d_err_r <= 1'b0;
            if (resp_fire_s) begin
                if (owner_r == MST_DATA) begin
                    d_data_r <= resp_data_s;
                    d_ok_r   <= 1'b1;
                    d_err_r  <= timeout_s;
                end else begin
                    f_data_r <= resp_data_s;
                    f_ok_r   <= 1'b1;
                    f_err_r  <= timeout_s;
                end
            end
        end
    end

    assign request_o = request_r;
    assign addr_o    = addr_r;
    assign fData_o   = f_data_r;
    assign fDataOk_o = f_ok_r;
    assign fErr_o    = f_err_r;
    assign dData_o   = d_data_r;
    assign dDataOk_o = d_ok_r;
    assign dErr_o    = d_err_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_port_arbiter
// Scoreboard bench: each master pushes its expected response when it raises a
// request; a monitor pops and compares on every DataOk_o pulse. The ROM model
// derives both data and response delay from the address, so the expected
// result of any request depends only on the address and the timeout rule.
// -----------------------------------------------------------------------------
module tb_rom_port_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        reset_n;
    logic        fRequest_i, dRequest_i;
    logic [31:0] fAddr_i, dAddr_i;
    logic [31:0] fData_o, dData_o;
    logic        fDataOk_o, fErr_o, dDataOk_o, dErr_o;
    logic        request_o;
    logic [31:0] addr_o;
    logic [31:0] data_i;
    logic        dataOk_i;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_f[$];
    exp_t        exp_d[$];
    int          resp_m[$];
    int          resp_c[$];
    logic [31:0] req_addr [2];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_req_cyc;
    logic [31:0] last_req_addr;
    logic [31:0] mem_addr;
    bit          spur_en = 1'b0;
    bit          spur_all = 1'b0;

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fRequest_i (fRequest_i),
        .fAddr_i    (fAddr_i),
        .fData_o    (fData_o),
        .fDataOk_o  (fDataOk_o),
        .fErr_o     (fErr_o),
        .dRequest_i (dRequest_i),
        .dAddr_i    (dAddr_i),
        .dData_o    (dData_o),
        .dDataOk_o  (dDataOk_o),
        .dErr_o     (dErr_o),
        .request_o  (request_o),
        .addr_o     (addr_o),
        .data_i     (data_i),
        .dataOk_i   (dataOk_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ROM contents: 0x10 holds 0xDEADBEEF, everything else is a hash.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0;
    endfunction

    // Response delay in WAIT cycles is address bits [21:16]; >= 17 means never.
    function automatic int delay_of(input logic [31:0] a);
        return int'(a[21:16]);
    endfunction

    function automatic exp_t expect_of(input logic [31:0] a);
        exp_t e;
        e.err  = (delay_of(a) >= TO);
        e.data = e.err ? 32'h0 : rom(a);
        return e;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          sel;
        logic [5:0]  d;
        logic [13:0] lo;
        sel = int'($urandom_range(9, 0));
        if (sel < 5)       d = 6'($urandom_range(3, 0));
        else if (sel == 5) d = 6'd15;
        else if (sel == 6) d = 6'd16;
        else if (sel == 7) d = 6'd63;
        else               d = 6'($urandom_range(14, 4));
        lo = 14'($urandom);
        return {10'd0, d, lo, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_request_o"}, 64'(request_o), 64'd0);
        chk({tag, "_addr_o"},    64'(addr_o),    64'd0);
        chk({tag, "_fData_o"},   64'(fData_o),   64'd0);
        chk({tag, "_fDataOk_o"}, 64'(fDataOk_o), 64'd0);
        chk({tag, "_fErr_o"},    64'(fErr_o),    64'd0);
        chk({tag, "_dData_o"},   64'(dData_o),   64'd0);
        chk({tag, "_dDataOk_o"}, 64'(dDataOk_o), 64'd0);
        chk({tag, "_dErr_o"},    64'(dErr_o),    64'd0);
    endtask

    // One master transaction: raise request, push expectation, await pulse.
    task automatic do_txn(input int m, input logic [31:0] a, input int gap,
                          output int req_cyc, output int rsp_cyc);
        bit got;
        repeat (gap) @(negedge clk);
        req_addr[m] = a;
        if (m == 0) begin
            fAddr_i = a;
            fRequest_i = 1'b1;
            exp_f.push_back(expect_of(a));
        end else begin
            dAddr_i = a;
            dRequest_i = 1'b1;
            exp_d.push_back(expect_of(a));
        end
        req_cyc = cyc;
        rsp_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? fDataOk_o : dDataOk_o) begin
                got = 1'b1;
                rsp_cyc = cyc;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL master%0d_timeout: no DataOk_o within 100 cycles for addr 0x%0h", m, a);
        end
        if (m == 0) fRequest_i = 1'b0;
        else        dRequest_i = 1'b0;
    endtask

    task automatic run_master(input int m, input int n, input bit rnd, input logic [31:0] a);
        int rq, rs;
        for (int k = 0; k < n; k++) begin
            if (rnd) do_txn(m, rand_addr(), int'($urandom_range(3, 0)), rq, rs);
            else     do_txn(m, a, 0, rq, rs);
        end
    endtask

    // ROM model: answers request_o after the address-derived delay and, when
    // enabled, drives spurious dataOk_i while no transaction can be in WAIT.
    initial begin
        int fire, quiet, d;
        fire = 0;
        quiet = 0;
        dataOk_i = 1'b0;
        data_i = 32'h0;
        last_req_cyc = 0;
        last_req_addr = 32'h0;
        mem_addr = 32'h0;
        forever begin
            @(negedge clk);
            dataOk_i = 1'b0;
            data_i = $urandom;
            if (!reset_n) begin
                fire = 0;
                quiet = 0;
            end else begin
                if (fire > 0) begin
                    fire--;
                    if (fire == 0) begin
                        dataOk_i = 1'b1;
                        data_i = rom(mem_addr);
                    end
                end
                if (quiet > 0) quiet--;
                if (request_o) begin
                    chk("addr_o_owner",
                        64'((fRequest_i && addr_o == req_addr[0]) || (dRequest_i && addr_o == req_addr[1])),
                        64'd1);
                    mem_addr = addr_o;
                    last_req_addr = addr_o;
                    last_req_cyc = cyc;
                    d = delay_of(addr_o);
                    fire = (d <= TO) ? d + 1 : 0;
                    quiet = TO + 2;
                end else if (fire == 0 && quiet == 0 &&
                             (spur_all || (spur_en && $urandom_range(3, 0) == 0))) begin
                    dataOk_i = 1'b1;
                end
            end
        end
    end

    // Monitor: every response pulse must match the owner's oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && (fDataOk_o || dDataOk_o)) begin
                chk("single_owner", 64'(fDataOk_o & dDataOk_o), 64'd0);
                if (fDataOk_o) begin
                    chk("f_resp_expected", 64'(exp_f.size() != 0), 64'd1);
                    if (exp_f.size() != 0) begin
                        e = exp_f.pop_front();
                        chk("f_data", 64'(fData_o), 64'(e.data));
                        chk("f_err",  64'(fErr_o),  64'(e.err));
                    end
                    resp_m.push_back(0);
                    resp_c.push_back(cyc);
                end
                if (dDataOk_o) begin
                    chk("d_resp_expected", 64'(exp_d.size() != 0), 64'd1);
                    if (exp_d.size() != 0) begin
                        e = exp_d.pop_front();
                        chk("d_data", 64'(dData_o), 64'(e.data));
                        chk("d_err",  64'(dErr_o),  64'(e.err));
                    end
                    resp_m.push_back(1);
                    resp_c.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int rq, rs, n0;
        reset_n = 1'b0;
        fRequest_i = 1'b0;
        dRequest_i = 1'b0;
        fAddr_i = 32'h0;
        dAddr_i = 32'h0;
        req_addr[0] = 32'h0;
        req_addr[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        // Both masters held high from reset: F,D,F,D,F,D every 4 cycles.
        @(negedge clk);
        resp_m.delete();
        resp_c.delete();
        fork
            run_master(0, 3, 1'b0, 32'h0000_0000);
            run_master(1, 3, 1'b0, 32'h0000_0100);
        join
        chk("rr_count", 64'(resp_m.size()), 64'd6);
        for (int i = 0; i < resp_m.size(); i++) begin
            chk("rr_order", 64'(resp_m[i]), 64'(i % 2));
            if (i > 0) chk("rr_spacing", 64'(resp_c[i] - resp_c[i-1]), 64'd4);
        end

        // Single fetch of 0x10: request_o at N+1, response at N+3.
        repeat (2) @(negedge clk);
        do_txn(0, 32'h0000_0010, 1, rq, rs);
        chk("fetch_latency", 64'(rs - rq), 64'd3);
        chk("request_o_cycle", 64'(last_req_cyc), 64'(rq + 1));
        chk("addr_o_value", 64'(last_req_addr), 64'h10);
        @(negedge clk);
        chk("fData_o_hold", 64'(fData_o), 64'hDEAD_BEEF);

        // Timeout, data on final WAIT cycle, and data one cycle too late.
        do_txn(1, 32'h003F_0200, 1, rq, rs);
        chk("timeout_latency", 64'(rs - rq), 64'd18);
        do_txn(1, 32'h000F_0300, 1, rq, rs);
        chk("last_wait_latency", 64'(rs - rq), 64'd18);
        do_txn(1, 32'h0010_0400, 1, rq, rs);
        chk("late_data_latency", 64'(rs - rq), 64'd18);
        do_txn(0, 32'h0000_0044, 1, rq, rs);
        chk("idle_after_timeout", 64'(rs - rq), 64'd3);

        // Spurious dataOk_i while idle must not produce a response.
        repeat (TO + 4) @(negedge clk);
        n0 = resp_m.size();
        spur_all = 1'b1;
        repeat (10) @(negedge clk);
        spur_all = 1'b0;
        chk("spurious_no_resp", 64'(resp_m.size()), 64'(n0));
        do_txn(1, 32'h0000_0088, 1, rq, rs);
        chk("after_spurious_latency", 64'(rs - rq), 64'd3);

        // Reset pulsed during WAIT: outputs clear, no stale response.
        @(negedge clk);
        req_addr[0] = 32'h003F_0500;
        fAddr_i = 32'h003F_0500;
        fRequest_i = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        fRequest_i = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n0 = resp_m.size();
        repeat (20) @(negedge clk);
        chk("no_stale_resp", 64'(resp_m.size()), 64'(n0));
        do_txn(0, 32'h0000_0060, 0, rq, rs);
        chk("after_reset_latency", 64'(rs - rq), 64'd3);

        // Randomized concurrent traffic with random spurious dataOk_i.
        spur_en = 1'b1;
        fork
            run_master(0, 40, 1'b1, 32'h0);
            run_master(1, 40, 1'b1, 32'h0);
        join
        spur_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("drain_fetch", 64'(exp_f.size()), 64'd0);
        chk("drain_data",  64'(exp_d.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 Parameter TIMEOUT, default 16: maximum WAIT cycles before an error response (range 2..255).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 fRequest_i  input  1  fetch requester (master 0) request; level, held until its dataOk.
REQ-007 fAddr_i  input  ADDR_W  fetch byte address.
REQ-008 fData_o  output  DATA_W  fetch response data.
REQ-009 fDataOk_o  output  1  fetch response valid, one-cycle pulse.
REQ-010 fErr_o  output  1  fetch timeout flag, valid with fDataOk_o.
REQ-011 dRequest_i, dAddr_i, dData_o, dDataOk_o, dErr_o: data requester (master 1), same widths and meaning as REQ-006..010.
REQ-012 request_o  output  1  memory request, one-cycle pulse.
REQ-013 addr_o  output  ADDR_W  memory address, stable from ISSUE until next grant.
REQ-014 data_i  input  DATA_W  memory read data.
REQ-015 dataOk_i  input  1  memory response valid.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-017 IDLE: if any qualified request, latch winner's address into addr_o, record owner, go ISSUE; else stay.
REQ-018 Arbitration: single requester wins; both requesting -> master not granted last wins; after reset master 0 has priority.
REQ-019 Priority pointer updates on the IDLE->ISSUE transition only.
REQ-020 ISSUE: request_o=1 for exactly this cycle; clear timeout counter; always go WAIT.
REQ-021 WAIT: dataOk_i=1 -> capture data_i, err=0, go RESP; else increment counter; counter reaching TIMEOUT-1 without dataOk_i -> data=0, err=1, go RESP.
REQ-022 dataOk_i arriving in the same cycle the counter reaches TIMEOUT-1 counts as success (data wins).
REQ-023 dataOk_i in IDLE, ISSUE or RESP is ignored.
REQ-024 RESP: owner's DataOk_o=1, Data_o=captured data, Err_o=err, for exactly one cycle; non-owner outputs stay 0; go IDLE.
REQ-025 A master's request is not qualified in the cycle its DataOk_o is high (prevents double service of a held request).
REQ-026 Latency with single-cycle memory: request sampled in IDLE at cycle N -> request_o at N+1 -> dataOk_i at N+2 -> DataOk_o at N+3.
REQ-027 Back-to-back: next grant is sampled in RESP+1 (IDLE); sustained throughput one transaction per 4 cycles.
REQ-028 Data_o holds last value between pulses; only DataOk_o qualifies it.

Reset
REQ-029 reset_n low, asynchronously: state IDLE, pointer to master 0, counter 0, request_o=0, addr_o=0, all Data_o=0, DataOk_o=0, Err_o=0.
REQ-030 Reset mid-transaction drops the in-flight response; no DataOk_o issued after release until a new request is granted.

Structure
REQ-031 Shared package holds the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), master indices (FETCH=0, DATA=1) and the TIMEOUT default.
REQ-032 One sub-module rr_grant2: combinational two-way round-robin picker (requests, last-grant pointer -> grant one-hot); all other logic in rom_port_arbiter.

Verification
REQ-033 Single fetch fAddr_i=0x10 against the 1-cycle ROM model holding 0xDEADBEEF -> request_o at N+1 with addr_o=0x10, fDataOk_o at N+3 with fData_o=0xDEADBEEF, fErr_o=0.
REQ-034 Both requesters held high from reset, addresses 0x0/0x100 -> grants alternate F,D,F,D, DataOk_o pulses every 4 cycles, each with matching data.
REQ-035 Memory never asserts dataOk_i, TIMEOUT=16 -> dDataOk_o=1, dErr_o=1, dData_o=0 exactly 16 cycles after WAIT entry; FSM then IDLE.
REQ-036 dataOk_i forced on final WAIT cycle -> success response, Err_o=0.
REQ-037 reset_n pulsed low during WAIT -> all outputs 0 immediately; no stale DataOk_o after release; next request served with 3-cycle latency.
REQ-038 Spurious dataOk_i while IDLE -> no DataOk_o pulse, state unchanged.
